// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MEM pipeline stage: dmem req/ack access, load align/extend, MEM/WB registers
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN (trap misaligned halfword/word accesses)
module mem_stage_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [2:0]  wb_src_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] result_in,
    input  logic [31:0] csr_in,
    output logic        stall,
    output logic [2:0]  wb_src,
    output logic [4:0]  rd,
    output logic [31:0] dmem_dataout,
    output logic [31:0] result,
    output logic [31:0] csr_dataout,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        bus_err,
    output logic        misalign,
    output logic [31:0] misalign_addr
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cap_wr;
    logic [2:0]       cap_f3;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_sdata;
    logic [2:0]       cap_wb;
    logic [4:0]       cap_rd;
    logic [31:0]      cap_result;
    logic [31:0]      cap_csr;
    logic             mem_op;
    logic             mis_det;
    logic             tmo_hit;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_val;

    assign mem_op = in_valid & (mem_rd | mem_wr);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // funct3[1:0]: 00 byte, 01 half, 1x word (reserved encodings fall into word)
    assign mis_det = mem_op & (((funct3[1:0] == 2'b01) & addr[0]) |
                               (funct3[1] & (addr[1:0] != 2'b00)));
`else
    assign mis_det = 1'b0;
`endif

    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);
    assign stall     = (state == ACCESS);
    assign dmem_req  = (state == ACCESS);
    assign dmem_we   = cap_wr;
    assign dmem_addr = {cap_addr[31:2], 2'b00};

    always_comb begin
        dmem_wstrb = 4'b0000;
        dmem_wdata = cap_sdata;
        case (cap_f3[1:0])
            2'b00: begin
                dmem_wdata = {4{cap_sdata[7:0]}};
                if (cap_wr) dmem_wstrb = 4'b0001 << cap_addr[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{cap_sdata[15:0]}};
                if (cap_wr) dmem_wstrb = 4'b0011 << {cap_addr[1], 1'b0};
            end
            default: begin
                if (cap_wr) dmem_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[{cap_addr[1:0], 3'b000} +: 8];
        ld_half = dmem_rdata[{cap_addr[1], 4'b0000} +: 16];
        case (cap_f3[1:0])
            2'b00:   ld_val = cap_f3[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = cap_f3[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cap_wr        <= 1'b0;
            cap_f3        <= 3'b000;
            cap_addr      <= 32'h0;
            cap_sdata     <= 32'h0;
            cap_wb        <= 3'b000;
            cap_rd        <= 5'd0;
            cap_result    <= 32'h0;
            cap_csr       <= 32'h0;
            wb_src        <= 3'b000;
            rd            <= 5'd0;
            dmem_dataout  <= 32'h0;
            result        <= 32'h0;
            csr_dataout   <= 32'h0;
            bus_err       <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= 32'h0;
        end else begin
            bus_err  <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mis_det) begin
                        misalign      <= 1'b1;
                        misalign_addr <= addr;
                        wb_src        <= 3'b000;
                    end else if (mem_op) begin
                        // store wins when both mem_rd and mem_wr are set
                        cap_wr     <= mem_wr;
                        cap_f3     <= funct3;
                        cap_addr   <= addr;
                        cap_sdata  <= store_data;
                        cap_wb     <= wb_src_in;
                        cap_rd     <= rd_in;
                        cap_result <= result_in;
                        cap_csr    <= csr_in;
                        wb_src     <= 3'b000;
                        state      <= ACCESS;
                    end else if (in_valid) begin
                        wb_src      <= wb_src_in;
                        rd          <= rd_in;
                        result      <= result_in;
                        csr_dataout <= csr_in;
                    end else begin
                        wb_src <= 3'b000;
                    end
                end
                ACCESS: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (dmem_ack) begin
                        if (!cap_wr) dmem_dataout <= ld_val;
                        wb_src      <= cap_wb;
                        rd          <= cap_rd;
                        result      <= cap_result;
                        csr_dataout <= cap_csr;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else if (tmo_hit) begin
                        bus_err <= 1'b1;
                        wb_src  <= 3'b000;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - randomized self-checking bench for mem_stage_unit against a transaction-level model
module tb_mem_stage_unit;
    localparam int TMO = 4;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [2:0]  wb_src_in;
    logic [4:0]  rd_in;
    logic [31:0] result_in;
    logic [31:0] csr_in;
    logic        stall;
    logic [2:0]  wb_src;
    logic [4:0]  rd;
    logic [31:0] dmem_dataout;
    logic [31:0] result;
    logic [31:0] csr_dataout;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        bus_err;
    logic        misalign;
    logic [31:0] misalign_addr;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    int drv_delay = 0;

    // reference model state
    logic        m_busy;
    logic        m_acc;
    int          m_el;
    int          m_delay;
    logic        t_wr;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_sd, t_res, t_csr;
    logic [2:0]  t_wb;
    logic [4:0]  t_rd;
    logic [2:0]  e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_res, e_csr, e_dout, e_mis_addr;
    logic        e_berr, e_mis;

    mem_stage_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .funct3(funct3), .addr(addr), .store_data(store_data), .wb_src_in(wb_src_in),
        .rd_in(rd_in), .result_in(result_in), .csr_in(csr_in), .stall(stall),
        .wb_src(wb_src), .rd(rd), .dmem_dataout(dmem_dataout), .result(result),
        .csr_dataout(csr_dataout), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .bus_err(bus_err),
        .misalign(misalign), .misalign_addr(misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_of(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        int off = int'(a % 32'd4);
        return (off / sz) * sz;
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        return (sz > 1) && ((int'(a % 32'd4) % sz) != 0);
    endfunction

    function automatic logic [3:0] exp_strb(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        int ln = lane_of(f3, a);
        if (!wr) return 4'b0000;
        return 4'(((1 << sz) - 1) << ln);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = size_of(f3);
        if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        int sz = size_of(f3);
        logic [31:0] v = rdata >> (8 * lane_of(f3, a));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_acc <= 1'b0; m_el <= 0; m_delay <= 0;
            e_wb <= 3'b000; e_rd <= 5'd0; e_res <= 32'h0; e_csr <= 32'h0; e_dout <= 32'h0;
            e_berr <= 1'b0; e_mis <= 1'b0; e_mis_addr <= 32'h0;
            t_wr <= 1'b0; t_f3 <= 3'b000; t_addr <= 32'h0; t_sd <= 32'h0;
            t_wb <= 3'b000; t_rd <= 5'd0; t_res <= 32'h0; t_csr <= 32'h0;
        end else begin
            e_berr <= 1'b0;
            e_mis  <= 1'b0;
            m_acc  <= 1'b0;
            if (!m_busy) begin
                if (in_valid) m_acc <= 1'b1;
                if (in_valid && (mem_rd || mem_wr) && TRAP_EN && is_misaligned(funct3, addr)) begin
                    e_mis <= 1'b1; e_mis_addr <= addr; e_wb <= 3'b000;
                end else if (in_valid && (mem_rd || mem_wr)) begin
                    m_busy <= 1'b1; m_el <= 0; m_delay <= drv_delay;
                    t_wr <= mem_wr; t_f3 <= funct3; t_addr <= addr; t_sd <= store_data;
                    t_wb <= wb_src_in; t_rd <= rd_in; t_res <= result_in; t_csr <= csr_in;
                    e_wb <= 3'b000;
                end else if (in_valid) begin
                    e_wb <= wb_src_in; e_rd <= rd_in; e_res <= result_in; e_csr <= csr_in;
                end else begin
                    e_wb <= 3'b000;
                end
            end else if (dmem_ack) begin
                m_busy <= 1'b0;
                e_wb <= t_wb; e_rd <= t_rd; e_res <= t_res; e_csr <= t_csr;
                if (!t_wr) e_dout <= load_value(t_f3, t_addr, dmem_rdata);
            end else if (TMO != 0 && m_el + 1 == TMO) begin
                m_busy <= 1'b0; e_berr <= 1'b1; e_wb <= 3'b000;
            end else begin
                m_el <= m_el + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stall", 32'(stall), 32'(m_busy));
            chk("dmem_req", 32'(dmem_req), 32'(m_busy));
            chk("wb_src", 32'(wb_src), 32'(e_wb));
            chk("rd", 32'(rd), 32'(e_rd));
            chk("result", result, e_res);
            chk("csr_dataout", csr_dataout, e_csr);
            chk("dmem_dataout", dmem_dataout, e_dout);
            chk("bus_err", 32'(bus_err), 32'(e_berr));
            chk("misalign", 32'(misalign), 32'(e_mis));
            chk("misalign_addr", misalign_addr, e_mis_addr);
            if (m_busy) begin
                chk("dmem_we", 32'(dmem_we), 32'(t_wr));
                chk("dmem_addr", dmem_addr, t_addr & 32'hFFFF_FFFC);
                chk("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_strb(t_wr, t_f3, t_addr)));
                if (t_wr) chk("dmem_wdata", dmem_wdata, exp_wdata(t_f3, t_sd));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (m_acc) in_valid = 1'b0;
        if (m_busy) dmem_ack = (m_el == m_delay);
        else        dmem_ack = ($urandom_range(0, 7) == 0);
    endtask

    task automatic set_instr(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd, input logic [2:0] wb,
                             input logic [4:0] rdi, input logic [31:0] res, input int dly,
                             input logic [31:0] rdata);
        in_valid = 1'b1; mem_rd = rd_op; mem_wr = wr_op; funct3 = f3; addr = a;
        store_data = sd; wb_src_in = wb; rd_in = rdi; result_in = res;
        csr_in = res ^ 32'h5A5A_0000; drv_delay = dly; dmem_rdata = rdata;
    endtask

    task automatic run_idle();
        int n = 0;
        do begin
            tick();
            n++;
        end while (stall && n < 20);
        chk("wait_idle", 32'(stall), 32'h0);
    endtask

    task automatic gen_random();
        int k = $urandom_range(0, 9);
        in_valid   = (k != 0);
        mem_rd     = (k >= 4 && k <= 6) || k == 9;
        mem_wr     = (k >= 7);
        funct3     = 3'($urandom_range(0, 7));
        addr       = $urandom();
        store_data = $urandom();
        wb_src_in  = 3'($urandom_range(0, 7));
        rd_in      = 5'($urandom_range(0, 31));
        result_in  = $urandom();
        csr_in     = $urandom();
        dmem_rdata = $urandom();
        drv_delay  = $urandom_range(0, 5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int nreq;
        int nerr;
        rst_n = 1'b0; in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; wb_src_in = 3'b000; rd_in = 5'd0;
        result_in = 32'h0; csr_in = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_wb_src", 32'(wb_src), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_req", 32'(dmem_req), 32'h0);
        chk("reset_dataout", dmem_dataout, 32'h0);
        chk("reset_bus_err", 32'(bus_err), 32'h0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // ALU op: one-cycle pass-through
        set_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 3'b101, 5'd5, 32'h1234, 0, 32'h0);
        tick();
        chk("alu_wb_src", 32'(wb_src), 32'h5);
        chk("alu_rd", 32'(rd), 32'h5);
        chk("alu_result", result, 32'h1234);
        chk("alu_stall", 32'(stall), 32'h0);

        // LB at 0x103 with 3 wait cycles
        set_instr(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 3'b100, 5'd7, 32'h55, 3, 32'h80FF_FF00);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!stall) break;
            n++;
            chk("lb_addr", dmem_addr, 32'h100);
        end
        chk("lb_stall_cycles", 32'(n), 32'd4);
        chk("lb_data", dmem_dataout, 32'hFFFF_FF80);
        chk("lb_wb_src", 32'(wb_src), 32'h4);

        // LHU at 0x2
        set_instr(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 3'b100, 5'd9, 32'h0, 0, 32'hBEEF_0000);
        run_idle();
        chk("lhu_data", dmem_dataout, 32'h0000_BEEF);

        // SB at 0x2, immediate ack
        set_instr(1'b0, 1'b1, 3'b000, 32'h2, 32'hAB, 3'b000, 5'd0, 32'h0, 0, 32'h0);
        tick();
        chk("sb_we", 32'(dmem_we), 32'h1);
        chk("sb_wstrb", 32'(dmem_wstrb), 32'h4);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        run_idle();
        chk("sb_wb_en", 32'(wb_src[2]), 32'h0);

        // load with no ack: timeout after TMO cycles
        set_instr(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 3'b100, 5'd3, 32'h0, 99, 32'h0);
        nreq = 0;
        nerr = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dmem_req) nreq++;
            if (bus_err) begin
                nerr++;
                chk("tmo_wb_src", 32'(wb_src), 32'h0);
                chk("tmo_stall", 32'(stall), 32'h0);
            end
        end
        chk("tmo_req_cycles", 32'(nreq), 32'd4);
        chk("tmo_bus_err_pulses", 32'(nerr), 32'd1);

        // LW at 0x6
        set_instr(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 3'b100, 5'd4, 32'h0, 0, 32'h1111_2222);
        tick();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        chk("mis_pulse", 32'(misalign), 32'h1);
        chk("mis_addr", misalign_addr, 32'h6);
        chk("mis_req", 32'(dmem_req), 32'h0);
        tick();
        chk("mis_pulse_end", 32'(misalign), 32'h0);
`else
        chk("lw6_addr", dmem_addr, 32'h4);
        chk("lw6_wstrb", 32'(dmem_wstrb), 32'h0);
        run_idle();
        chk("lw6_data", dmem_dataout, 32'h1111_2222);
`endif

        // reset in the middle of an access
        set_instr(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 3'b100, 5'd2, 32'h0, 99, 32'h0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'h0);
        chk("midrst_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!in_valid) gen_random();
        end
        in_valid = 1'b0;
        run_idle();
        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Memory-access pipeline stage between execute and writeback.
- Accepts one instruction per cycle from EX and drives the data-memory req/ack interface for loads and stores.
- Aligns and extends load data, then registers the MEM/WB fields (wb_src, rd, dmem_dataout, result, csr_dataout) consumed by the writeback unit.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in ACCESS without dmem_ack before bus error; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX presents a valid instruction
- mem_rd  in  1  instruction is a load
- mem_wr  in  1  instruction is a store
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- store_data  in  32  rs2 value, unaligned
- wb_src_in  in  3  writeback control; bit2 = write enable, [1:0] = WB_DATAMEM/WB_RESULT/WB_CSR_DATAOUT select
- rd_in  in  5  destination register
- result_in  in  32  ALU result
- csr_in  in  32  CSR read data
- stall  out  1  upstream must hold its outputs
- wb_src  out  3  registered to WB
- rd  out  5  registered to WB
- dmem_dataout  out  32  registered, aligned/extended load data
- result  out  32  registered
- csr_dataout  out  32  registered
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wstrb  out  4  byte write strobes
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  memory read word, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- bus_err  out  1  one-cycle pulse on timeout
- misalign  out  1  one-cycle pulse (optional feature)
- misalign_addr  out  32  faulting address (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, counter = 0.
  - All registered outputs = 0, including wb_src = 000 (bubble); dmem_req, bus_err, misalign = 0.
  - Reset mid-ACCESS drops dmem_req immediately and discards the instruction.
- stall = (state == ACCESS), decoded from the state register only; no combinational path from inputs.
- IDLE:
  - in_valid high with neither mem_rd nor mem_wr: next edge registers wb_src_in, rd_in, result_in, csr_in; dmem_dataout keeps its value. Latency 1.
  - in_valid low: next edge registers wb_src = 000.
  - in_valid high with mem_rd or mem_wr: next edge captures op, funct3, addr, store_data, wb_src_in, rd_in, result_in, csr_in; enters ACCESS; registers wb_src = 000.
- ACCESS:
  - dmem_req = 1; dmem_we, dmem_addr, dmem_wstrb, dmem_wdata driven from the captured fields and stable until ack.
  - Counter increments each cycle.
  - On dmem_ack, at that edge: load data is extracted and registered into dmem_dataout; captured wb_src/rd/result/csr_dataout are registered; return to IDLE; counter cleared.
  - Load/store latency = 2 + memory wait cycles.
  - An instruction presented during ACCESS is held by upstream and accepted in the following IDLE cycle.
- Timeout: counter reaching TIMEOUT_CYCLES without ack drops dmem_req, pulses bus_err, registers wb_src = 000, and returns to IDLE.
- Priority and boundary cases:
  - ack on the timeout cycle: ack wins.
  - ack in IDLE: ignored.
  - mem_rd and mem_wr both set: store wins.
  - Reserved funct3: treated as word.
- Store strobes and data:
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: wstrb = 0011 << {addr[1],0}; wdata = halfword replicated x2.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction:
  - Byte = dmem_rdata[8*addr[1:0] +: 8]; halfword = dmem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - Halfword op with addr[0] = 1, or word op with addr[1:0] != 0, issues no memory access and stays in IDLE.
  - Next edge pulses misalign, sets misalign_addr = addr, and registers wb_src = 000.
- Undefined:
  - misalign and misalign_addr are tied to 0.
  - Halfword ops ignore addr[0]; word ops ignore addr[1:0].

Test Plan:
- ALU op, wb_src_in = 1_01 (write, WB_RESULT), rd_in = 5, result_in = 0x1234 -> one cycle later wb_src = 101, rd = 5, result = 0x1234, stall never high.
- LB at addr 0x103, ack after 3 wait cycles, dmem_rdata = 0x80FF_FF00 -> stall high 4 cycles, dmem_addr = 0x100, dmem_dataout = 0xFFFF_FF80.
- LHU at addr 0x2, dmem_rdata = 0xBEEF_0000 -> dmem_dataout = 0x0000_BEEF.
- SB at addr 0x2, store_data = 0xAB, immediate ack -> dmem_we = 1, wstrb = 0100, wdata = 0xABAB_ABAB, wb_src[2] = 0.
- Load with no ack, TIMEOUT_CYCLES = 4 -> dmem_req falls after 4 cycles, bus_err pulses once, wb_src = 000, stall low the next cycle.
- With MEM_STAGE_MISALIGN_TRAP_EN: LW at 0x6 -> dmem_req never high, misalign pulses, misalign_addr = 0x6. Without it: access to 0x4, wstrb = 0000.
